// File: rtl/if_pc_fetch_pkg.sv
// Shared constants, state encoding and JAL predecode helpers for the IF stage.
package if_pc_fetch_pkg;

    localparam int          ZCRV_ADDR_SIZE  = 32;
    localparam int          ZCRV_XLEN       = 32;
    localparam logic [31:0] ZCRV_RESET_PC   = 32'h0000_0000;
    localparam logic [6:0]  ZCRV_OPCODE_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_WAIT = 2'd2
    } if_state_e;

    // J-type immediate, bit 0 always zero; caller sign-extends bit 20.
    function automatic logic signed [20:0] jal_imm(input logic [31:12] hi);
        return {hi[31], hi[19:12], hi[20], hi[30:21], 1'b0};
    endfunction

    function automatic logic is_jal(input logic [6:0] opcode);
        return opcode == ZCRV_OPCODE_JAL;
    endfunction

endpackage

// File: rtl/if_inst_fifo.sv
// Two-entry {inst, pc} buffer between the fetch bus and ID. Entry 0 is the
// head; when empty the head keeps the last delivered values.
module if_inst_fifo
    import if_pc_fetch_pkg::*;
#(
    parameter int ADDR_W = ZCRV_ADDR_SIZE,
    parameter int XLEN   = ZCRV_XLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [XLEN-1:0]   push_inst_i,
    input  logic [ADDR_W-1:0] push_pc_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic [1:0]        count_o,
    output logic              valid_o,
    output logic [XLEN-1:0]   inst_o,
    output logic [ADDR_W-1:0] pc_o
);

    logic [1:0]        count_q, count_d;
    logic [XLEN-1:0]   inst0_q, inst0_d, inst1_q, inst1_d;
    logic [ADDR_W-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
    logic              pop_eff;
    logic              push_eff;

    // Next-state: shift the head on pop, place a push in the first free slot.
    always_comb begin
        count_d  = count_q;
        inst0_d  = inst0_q;
        pc0_d    = pc0_q;
        inst1_d  = inst1_q;
        pc1_d    = pc1_q;
        pop_eff  = pop_i && (count_q != 2'd0);
        push_eff = push_i && ((count_q != 2'd2) || pop_eff);

        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            if (pop_eff && (count_q == 2'd2)) begin
                inst0_d = inst1_q;
                pc0_d   = pc1_q;
            end
            if (push_eff) begin
                if ((count_q == 2'd0) || ((count_q == 2'd1) && pop_eff)) begin
                    inst0_d = push_inst_i;
                    pc0_d   = push_pc_i;
                end else begin
                    inst1_d = push_inst_i;
                    pc1_d   = push_pc_i;
                end
            end
            count_d = count_q + {1'b0, push_eff} - {1'b0, pop_eff};
        end
    end

    // Head entry and occupancy; head is cleared on reset so ID sees zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            inst0_q <= '0;
            pc0_q   <= '0;
        end else begin
            count_q <= count_d;
            inst0_q <= inst0_d;
            pc0_q   <= pc0_d;
        end
    end

    // Second entry is pure data and only meaningful while count is 2.
    always_ff @(posedge clk) begin
        inst1_q <= inst1_d;
        pc1_q   <= pc1_d;
    end

    assign count_o = count_q;
    assign valid_o = (count_q != 2'd0);
    assign inst_o  = inst0_q;
    assign pc_o    = pc0_q;

endmodule

// File: rtl/if_pc_fetch.sv
// IF stage: PC generation, single-outstanding instruction-bus fetch, JAL
// predecode redirect and EX redirect handling, feeding a 2-entry buffer to ID.
module if_pc_fetch
    import if_pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = ZCRV_RESET_PC,
    parameter int          ADDR_W   = ZCRV_ADDR_SIZE,
    parameter int          XLEN     = ZCRV_XLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_jump_valid,
    input  logic [ADDR_W-1:0] ex_jump_dest,
    output logic              ibus_req,
    output logic [ADDR_W-1:0] ibus_addr,
    input  logic              ibus_gnt,
    input  logic              ibus_rvalid,
    input  logic [XLEN-1:0]   ibus_rdata,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [XLEN-1:0]   id_inst,
    output logic [ADDR_W-1:0] id_pc
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [ADDR_W-1:0] RST_PC     = ADDR_W'(RESET_PC) & ALIGN_MASK;

    if_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              req_pend_q, req_pend_d;
    logic              drop_q, drop_d;

    logic [1:0]          fifo_count;
    logic                outstanding;
    logic                rsp_fire;
    logic                rsp_accept;
    logic signed [20:0]  j_imm;
    logic [ADDR_W-1:0]   j_off;

    assign outstanding = (state_q == IF_WAIT);
    assign ibus_req    = (state_q == IF_REQ) &&
                         (({1'b0, fifo_count} + {2'b00, outstanding}) < 3'd2);
    // Once the request is visible its address is frozen until granted.
    assign ibus_addr   = req_pend_q ? req_addr_q : pc_q;
    assign rsp_fire    = outstanding && ibus_rvalid;
    assign rsp_accept  = rsp_fire && !drop_q && !ex_jump_valid;
    assign j_imm       = jal_imm(ibus_rdata[31:12]);
    assign j_off       = {{(ADDR_W-21){j_imm[20]}}, j_imm};

    // Fetch control: state, next PC, pending-request hold and drop tracking.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        req_pend_d = req_pend_q;
        drop_d     = drop_q;

        unique case (state_q)
            IF_IDLE: state_d = IF_REQ;
            IF_REQ: begin
                if (ibus_req && ibus_gnt) begin
                    state_d    = IF_WAIT;
                    fetch_pc_d = ibus_addr;
                    req_pend_d = 1'b0;
                end else if (ibus_req) begin
                    req_pend_d = 1'b1;
                    req_addr_d = ibus_addr;
                end
            end
            IF_WAIT: begin
                if (ibus_rvalid) begin
                    state_d = IF_REQ;
                end
            end
            default: state_d = IF_IDLE;
        endcase

        // A returning response always retires any pending drop.
        if (rsp_fire) begin
            drop_d = 1'b0;
        end

        // EX redirect wins over predecode; a bus transaction already in
        // flight for the old path must have its response discarded.
        if (ex_jump_valid) begin
            pc_d = ex_jump_dest & ALIGN_MASK;
            if (((state_q == IF_WAIT) && !ibus_rvalid) ||
                ((state_q == IF_REQ) && ibus_req)) begin
                drop_d = 1'b1;
            end
        end else if (rsp_accept) begin
            if (is_jal(ibus_rdata[6:0])) begin
                pc_d = (fetch_pc_q + j_off) & ALIGN_MASK;
            end else begin
                pc_d = fetch_pc_q + ADDR_W'(4);
            end
        end
    end

    // Control registers; synchronous reset aborts any bus transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IF_IDLE;
            pc_q       <= RST_PC;
            fetch_pc_q <= RST_PC;
            req_addr_q <= RST_PC;
            req_pend_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            req_pend_q <= req_pend_d;
            drop_q     <= drop_d;
        end
    end

    if_inst_fifo #(
        .ADDR_W (ADDR_W),
        .XLEN   (XLEN)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (rsp_accept),
        .push_inst_i (ibus_rdata),
        .push_pc_i   (fetch_pc_q),
        .pop_i       (id_valid && id_ready),
        .flush_i     (ex_jump_valid),
        .count_o     (fifo_count),
        .valid_o     (id_valid),
        .inst_o      (id_inst),
        .pc_o        (id_pc)
    );

endmodule

// File: tb/tb_if_pc_fetch.sv
// Directed bench for if_pc_fetch: sequential fetch, back-pressure, EX
// redirects, JAL predecode, held requests and reset mid-transaction.
module tb_if_pc_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_jump_valid;
    logic [31:0] ex_jump_dest;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_gnt;
    logic        ibus_rvalid;
    logic [31:0] ibus_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    int n_chk  = 0;
    int n_pass = 0;
    logic ovf_seen = 1'b0;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] JAL_P40 = 32'h0400_00EF;
    localparam logic [31:0] JAL_M4  = 32'hFFDF_F06F;

    if_pc_fetch #(
        .RESET_PC (32'h0000_0000),
        .ADDR_W   (32),
        .XLEN     (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_jump_valid (ex_jump_valid),
        .ex_jump_dest  (ex_jump_dest),
        .ibus_req      (ibus_req),
        .ibus_addr     (ibus_addr),
        .ibus_gnt      (ibus_gnt),
        .ibus_rvalid   (ibus_rvalid),
        .ibus_rdata    (ibus_rdata),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_inst       (id_inst),
        .id_pc         (id_pc)
    );

    always #5 clk = ~clk;

    // Buffer occupancy must never exceed its two entries.
    always @(negedge clk) begin
        if (dut.fifo_count > 2'd2) ovf_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grant the current request, return rdata the following cycle.
    task automatic fetch(input logic [31:0] data);
        ibus_gnt = 1'b1;
        tick();
        ibus_gnt    = 1'b0;
        ibus_rvalid = 1'b1;
        ibus_rdata  = data;
        tick();
        ibus_rvalid = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},   32'(ibus_req), 32'd0);
        chk({tag, "_addr"},  ibus_addr,     32'h0);
        chk({tag, "_valid"}, 32'(id_valid), 32'd0);
        chk({tag, "_inst"},  id_inst,       32'h0);
        chk({tag, "_pc"},    id_pc,         32'h0);
    endtask

    initial begin
        rst = 1'b1; ex_jump_valid = 1'b0; ex_jump_dest = '0;
        ibus_gnt = 1'b0; ibus_rvalid = 1'b0; ibus_rdata = '0; id_ready = 1'b1;
        tick(); tick();
        chk_reset("rst");

        // 1: first fetch, latency and sequential advance
        rst = 1'b0;
        tick();
        chk("t1_req", 32'(ibus_req), 32'd1);
        chk("t1_addr0", ibus_addr, 32'h0);
        ibus_gnt = 1'b1;
        tick();
        ibus_gnt = 1'b0;
        chk("t1_req_wait", 32'(ibus_req), 32'd0);
        ibus_rvalid = 1'b1; ibus_rdata = NOP;
        tick();
        ibus_rvalid = 1'b0;
        chk("t1_valid", 32'(id_valid), 32'd1);
        chk("t1_pc", id_pc, 32'h0);
        chk("t1_inst", id_inst, NOP);
        chk("t1_next_addr", ibus_addr, 32'h4);

        // 2: back-pressure fills both entries and stalls requests
        id_ready = 1'b0;
        fetch(NOP);
        chk("t2_req_full", 32'(ibus_req), 32'd0);
        chk("t2_hold_pc", id_pc, 32'h0);
        tick();
        chk("t2_req_full2", 32'(ibus_req), 32'd0);
        chk("t2_hold_pc2", id_pc, 32'h0);
        chk("t2_valid", 32'(id_valid), 32'd1);
        id_ready = 1'b1;
        tick();
        chk("t2_pop_pc4", id_pc, 32'h4);
        chk("t2_req_resume", 32'(ibus_req), 32'd1);
        chk("t2_addr8", ibus_addr, 32'h8);
        tick();
        chk("t2_empty", 32'(id_valid), 32'd0);
        chk("t2_empty_hold", id_pc, 32'h4);

        // 3: EX redirect during WAIT drops the response and flushes
        fetch(NOP);
        fetch(NOP);
        chk("t3_addr10", ibus_addr, 32'h10);
        id_ready = 1'b0;
        ibus_gnt = 1'b1;
        tick();
        ibus_gnt = 1'b0;
        chk("t3_buf_c", id_pc, 32'hC);
        ex_jump_valid = 1'b1; ex_jump_dest = 32'h100;
        tick();
        ex_jump_valid = 1'b0;
        chk("t3_flushed", 32'(id_valid), 32'd0);
        chk("t3_no_req", 32'(ibus_req), 32'd0);
        ibus_rvalid = 1'b1; ibus_rdata = NOP;
        tick();
        ibus_rvalid = 1'b0;
        chk("t3_dropped", 32'(id_valid), 32'd0);
        chk("t3_addr100", ibus_addr, 32'h100);
        id_ready = 1'b1;
        fetch(NOP);
        chk("t3_pc100", id_pc, 32'h100);
        chk("t3_addr104", ibus_addr, 32'h104);

        // 4: redirect to 0x20 with a same-cycle response, then JAL +0x40
        ibus_gnt = 1'b1;
        tick();
        ibus_gnt = 1'b0;
        ibus_rvalid = 1'b1; ibus_rdata = NOP;
        ex_jump_valid = 1'b1; ex_jump_dest = 32'h20;
        tick();
        ibus_rvalid = 1'b0; ex_jump_valid = 1'b0;
        chk("t4_addr20", ibus_addr, 32'h20);
        fetch(JAL_P40);
        chk("t4_jal_valid", 32'(id_valid), 32'd1);
        chk("t4_jal_pc", id_pc, 32'h20);
        chk("t4_jal_inst", id_inst, JAL_P40);
        chk("t4_jal_target", ibus_addr, 32'h60);

        // 5: EX redirect beats a JAL in the same cycle; dest low bits masked
        ibus_gnt = 1'b1;
        tick();
        ibus_gnt = 1'b0;
        ibus_rvalid = 1'b1; ibus_rdata = JAL_P40;
        ex_jump_valid = 1'b1; ex_jump_dest = 32'h203;
        tick();
        ibus_rvalid = 1'b0; ex_jump_valid = 1'b0;
        chk("t5_no_jal", 32'(id_valid), 32'd0);
        chk("t5_addr200", ibus_addr, 32'h200);

        // 6a: redirect while request held without grant
        chk("t6_req", 32'(ibus_req), 32'd1);
        ex_jump_valid = 1'b1; ex_jump_dest = 32'h300;
        tick();
        ex_jump_valid = 1'b0;
        chk("t6_hold1", ibus_addr, 32'h200);
        chk("t6_req1", 32'(ibus_req), 32'd1);
        tick();
        chk("t6_hold2", ibus_addr, 32'h200);
        tick();
        chk("t6_hold3", ibus_addr, 32'h200);
        fetch(NOP);
        chk("t6_dropped", 32'(id_valid), 32'd0);
        chk("t6_addr300", ibus_addr, 32'h300);
        fetch(NOP);
        chk("t6_pc300", id_pc, 32'h300);

        // 6b: reset during WAIT ignores the late response
        ibus_gnt = 1'b1;
        tick();
        ibus_gnt = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset("t6_rst");
        ibus_rvalid = 1'b1; ibus_rdata = JAL_P40;
        tick();
        ibus_rvalid = 1'b0;
        chk("t6_late_ignored", 32'(id_valid), 32'd0);
        chk("t6_req_rst", 32'(ibus_req), 32'd1);
        chk("t6_addr_rst", ibus_addr, 32'h0);
        fetch(NOP);
        chk("t6_pc_rst", id_pc, 32'h0);
        chk("t6_addr4", ibus_addr, 32'h4);

        // Backward JAL (-4) at 0x4 returns to 0x0
        fetch(JAL_M4);
        chk("jal_back_pc", id_pc, 32'h4);
        chk("jal_back_target", ibus_addr, 32'h0);

        chk("no_overflow", 32'(ovf_seen), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/if_pc_fetch.md
Name: if_pc_fetch

Overview:
IF-stage PC generator and fetch buffer. It sits directly upstream of ID/EX and feeds the jump unit's input_pc (pc_present_to_idex) and instruction, and it consumes the jump unit's redirect (jump_whether_or_not / jump_dest). It also predecodes JAL so JAL redirects in IF, leaving EX to compute only the link value. One outstanding instruction-bus request, backed by a 2-entry output FIFO.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
ADDR_W, `ZCRV_ADDR_SIZE, PC/address width
XLEN, `ZCRV_XLEN, instruction/data width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ex_jump_valid  in  1  EX redirect request (jump_whether_or_not)
ex_jump_dest  in  ADDR_W  EX redirect target (jump_dest)
ibus_req  out  1  fetch request
ibus_addr  out  ADDR_W  fetch address, word aligned
ibus_gnt  in  1  request accepted this cycle
ibus_rvalid  in  1  read data valid, at least 1 cycle after gnt
ibus_rdata  in  XLEN  fetched instruction
id_valid  out  1  instruction available to ID
id_ready  in  1  ID accepts this cycle
id_inst  out  XLEN  instruction to ID
id_pc  out  ADDR_W  PC of id_inst (pc_present_to_idex)

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named rst.
- Reset: pc_q=RESET_PC, state IDLE, FIFO empty, drop_q=0, ibus_req=0, ibus_addr=RESET_PC, id_valid=0, id_inst=0, id_pc=0. Reset mid-transaction aborts it; any rvalid for the aborted request is ignored.
- States:
  - IDLE: first cycle after rst is released; go to REQ.
  - REQ: assert ibus_req only when fifo_count + outstanding < 2, where fifo_count is the registered count. On gnt, go to WAIT.
  - WAIT: on rvalid, go to REQ.
- ibus_req and ibus_addr stay stable from first assertion until gnt. A request is never retracted.
- Throughput: at most 1 instruction per 2 cycles (REQ with gnt, then WAIT with rvalid). Latency: rst low at cycle 0 gives req at cycle 1; with gnt at cycle 1 and rvalid at cycle 2, id_valid is high at cycle 3.
- ibus_addr[1:0] is always 0. The low 2 bits of any target are forced to 0; misalignment traps are out of scope.
- Response handling when rvalid && !drop_q && !ex_jump_valid:
  - push {rdata, fetch_pc} into the FIFO;
  - if rdata[6:0]==7'b1101111 (JAL), next pc = fetch_pc + sext(J-imm{rdata[31],rdata[19:12],rdata[20],rdata[30:21],1'b0}), wrapping mod 2^ADDR_W;
  - otherwise next pc = fetch_pc + 4, wrapping.
- Redirect priority: ex_jump_valid > JAL predecode > sequential.
- On ex_jump_valid (any state):
  - FIFO flushed next cycle (id_valid=0); pc_q=ex_jump_dest & ~3;
  - an rvalid in the same cycle is discarded, including a JAL;
  - in WAIT without rvalid, set drop_q, and the next rvalid is discarded then drop_q cleared;
  - in REQ with req asserted and no gnt, keep addr, set drop_q; after gnt and rvalid (dropped), issue REQ at the new pc;
  - in REQ with req not yet asserted, the next request uses the new pc.
- A second ex_jump_valid while drop_q=1 overwrites pc_q only.
- FIFO: 2 entries. Push and pop in the same cycle are allowed. id_inst/id_pc are held stable while id_valid && !id_ready. Overflow is impossible by the request rule; the bench checks it.
- FIFO empty gives id_valid=0, and id_inst/id_pc hold their last values.

Decomposition:
- Shared defines file: `ZCRV_RESET_PC, `ZCRV_OPCODE_JAL (7'b1101111), the IF state encodings (IDLE/REQ/WAIT), and the existing `ZCRV_ADDR_SIZE/`ZCRV_XLEN.
- One sub-module: if_inst_fifo, a 2-entry {inst,pc} FIFO with push, pop, flush and count.

Test Plan:
1. RESET_PC=0, gnt immediate, rvalid 1 cycle later with rdata 0x00000013 -> id_valid with id_pc=0, id_inst=0x13; next ibus_addr=0x4.
2. id_ready=0 -> after 2 instructions (pc 0x0, 0x4) are buffered, ibus_req stays 0 and id_pc holds 0x0; id_ready=1 -> pops 0x0 then 0x4, and the next request is at 0x8.
3. ex_jump_valid with dest 0x100 during WAIT for 0x10 -> 0x10 response dropped, FIFO flushed, next ibus_addr=0x100, next id_pc=0x100.
4. rdata 0x040000EF (jal x1,+0x40) at pc 0x20 -> delivered with id_pc=0x20; next ibus_addr=0x60.
5. ex_jump_valid (dest 0x200) in the same cycle as a JAL rvalid -> JAL not delivered, next ibus_addr=0x200.
6. Redirect to 0x300 while req is pending with gnt held low 3 cycles -> ibus_addr stays at the old value, response dropped, then fetch at 0x300. Separately, rst during WAIT -> the late rvalid is ignored and the first fetch is at RESET_PC.
